// File: rtl/dot_product_sched_pkg.sv
// Shared types and helpers for the dot-product scheduler: FSM states,
// default sizes, accumulator width rule and the round-robin picker.
package dot_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ELEM_W  = 8;
  localparam int DEF_VEC_LEN = 3;

  // Widest requester vector the picker can scan.
  localparam int RR_MAX = 32;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } rr_result_t;

  // Full-precision width for a sum of vec_len products of two elem_w operands.
  function automatic int acc_width(input int elem_w, input int vec_len);
    return 2 * elem_w + $clog2(vec_len + 1);
  endfunction

  // First set bit of valid at or above ptr, wrapping at num_req.
  function automatic rr_result_t rr_pick(input logic [RR_MAX-1:0] valid,
                                         input int unsigned      ptr,
                                         input int unsigned      num_req);
    rr_result_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      int unsigned i;
      i = ptr + k;
      if (i >= num_req) begin
        i = i - num_req;
      end
      if (k < num_req && !r.found && valid[i[4:0]]) begin
        r.found = 1'b1;
        r.idx   = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dot_product_sched_if.sv
// Requester-side and result-side handshake bundle of the scheduler.
// The master modport is the environment, the slave modport is the scheduler.
interface dot_product_sched_if #(
  parameter int NUM_REQ = dot_sched_pkg::DEF_NUM_REQ,
  parameter int ELEM_W  = dot_sched_pkg::DEF_ELEM_W,
  parameter int VEC_LEN = dot_sched_pkg::DEF_VEC_LEN
);

  localparam int ACC_W = dot_sched_pkg::acc_width(ELEM_W, VEC_LEN);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int BUS_W = NUM_REQ * VEC_LEN * ELEM_W;

  logic [NUM_REQ-1:0] req_valid;
  logic [BUS_W-1:0]   req_a;
  logic [BUS_W-1:0]   req_b;
  logic [NUM_REQ-1:0] req_ready;
  logic               res_valid;
  logic               res_ready;
  logic [ACC_W-1:0]   res_data;
  logic [ID_W-1:0]    res_id;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, busy
  );

endinterface

// File: rtl/dot_product_sched_mac.sv
// Serial multiply-accumulate datapath: one element pair per enabled cycle,
// cleared at the start of each operation.
module dot_mac #(
  parameter int ELEM_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              en,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  // Clear has priority so a new operation never inherits a stale sum.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(a) * ACC_W'(b);
    end
  end

endmodule

// File: rtl/dot_product_sched.sv
// Round-robin scheduler sharing one serial MAC between NUM_REQ vector
// requesters; returns each dot product tagged with its requester id.
module dot_product_sched
  import dot_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ELEM_W  = DEF_ELEM_W,
  parameter int VEC_LEN = DEF_VEC_LEN
) (
  input logic                clk,
  input logic                resetn,
  dot_product_sched_if.slave bus
);

  localparam int ACC_W = acc_width(ELEM_W, VEC_LEN);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int VEC_W = VEC_LEN * ELEM_W;
  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  state_t             state_q;
  state_t             state_d;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    winner;
  logic [CNT_W-1:0]   cnt_q;
  logic [VEC_W-1:0]   op_a_q;
  logic [VEC_W-1:0]   op_b_q;
  logic [VEC_W-1:0]   sel_a;
  logic [VEC_W-1:0]   sel_b;
  logic [RR_MAX-1:0]  valid_ext;
  logic [NUM_REQ-1:0] ready_d;
  rr_result_t         pick;
  logic               accept;
  logic               mac_en;
  logic [ACC_W-1:0]   acc;

  assign valid_ext = RR_MAX'(bus.req_valid);
  assign pick      = rr_pick(valid_ext, 32'(ptr_q), NUM_REQ);
  assign winner    = ID_W'(pick.idx);

  // Grants are suppressed while reset is asserted so req_ready reads zero.
  assign accept = resetn && (state_q == IDLE) && pick.found;
  assign mac_en = (state_q == BUSY);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_d = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ready_d[winner] = 1'b1;
          state_d         = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_a = bus.req_a[i*VEC_W +: VEC_W];
        sel_b = bus.req_b[i*VEC_W +: VEC_W];
      end
    end
  end

  // Operands shift down one element per BUSY cycle so the MAC always
  // consumes the low element; cnt wraps to zero on the last element.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_q  <= '0;
      id_q   <= '0;
      cnt_q  <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (accept) begin
      ptr_q  <= (winner == LAST_ID) ? '0 : winner + 1'b1;
      id_q   <= winner;
      cnt_q  <= '0;
      op_a_q <= sel_a;
      op_b_q <= sel_b;
    end else if (state_q == BUSY) begin
      op_a_q <= op_a_q >> ELEM_W;
      op_b_q <= op_b_q >> ELEM_W;
      cnt_q  <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
  end

  dot_mac #(
    .ELEM_W(ELEM_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .resetn(resetn),
    .clr   (accept),
    .en    (mac_en),
    .a     (op_a_q[ELEM_W-1:0]),
    .b     (op_b_q[ELEM_W-1:0]),
    .acc   (acc)
  );

  assign bus.req_ready = ready_d;
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = acc;
  assign bus.res_id    = id_q;
  assign bus.busy      = (state_q != IDLE);

  assert property (@(posedge clk) disable iff (!resetn) $onehot0(bus.req_ready));
  assert property (@(posedge clk) disable iff (!resetn)
                   (bus.req_ready != '0) |-> (state_q == IDLE));

endmodule
